eof_error_block: RTL and testbench



---
 rtl/can_pkg.sv | 18 +
 rtl/eof_bit_counter.sv | 45 ++++
 rtl/eof_error_block.sv | 100 ++++++++++
 tb/tb_eof_error_block.sv | 135 +++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// ---------------------------------------------------------------------------
// can_pkg
// Shared CAN receiver definitions: default End-of-Frame length, bus level
// encodings and the state type of the EOF checker.
// ---------------------------------------------------------------------------
package can_pkg;

  localparam int unsigned EOF_LEN_DEFAULT = 7;

  localparam logic CAN_DOMINANT  = 1'b0;
  localparam logic CAN_RECESSIVE = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } eof_state_t;

endpackage : can_pkg

// File: rtl/eof_bit_counter.sv
// ---------------------------------------------------------------------------
// eof_bit_counter
// Loadable 4-bit up-counter tracking the EOF bit index (0..LAST). Wraps to
// zero after reaching LAST so it is ready for the next field.
// Ports:
//   SP     in  sample-point clock, rising edge active
//   reset  in  synchronous active-high reset (count -> 0)
//   load   in  restart the count at 0 (arming edge)
//   enable in  advance the count by one bit
//   tc     out terminal count, high while the count equals LAST
// ---------------------------------------------------------------------------
module eof_bit_counter #(
  parameter int unsigned LAST = 6
) (
  input  logic SP,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic tc
);

  localparam logic [3:0] LAST_CNT = 4'(LAST);

  logic [3:0] cnt;

  assign tc = (cnt == LAST_CNT);

  // Bit index register: reset, load, then count with wrap at LAST.
  always_ff @(posedge SP) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= 4'd0;
    end else if (enable) begin
      if (tc) begin
        cnt <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end else begin
      cnt <= cnt;
    end
  end

endmodule : eof_bit_counter

// File: rtl/eof_error_block.sv
// ---------------------------------------------------------------------------
// eof_error_block
// CAN receiver End-of-Frame checker. Armed by EOF_Flag on the bit before the
// EOF field, it samples RX on each of the following EOF_LEN sample points and
// sets the sticky EOF_Error if a checked bit is dominant.
// Ports:
//   SP        in  sample-point clock, rising edge active
//   reset     in  synchronous active-high reset
//   RX        in  received bus bit (1 recessive, 0 dominant)
//   EOF_Flag  in  one-cycle arm pulse, bit preceding the first EOF bit
//   EOF_Error out registered sticky error flag
// Parameters:
//   EOF_LEN   number of EOF bits in the window (2..15)
// Configuration macro:
//   EOF_LAST_BIT_OVERLOAD_EN  when defined the last EOF bit is not checked
//                             (a dominant level there is an overload
//                             condition handled elsewhere).
// ---------------------------------------------------------------------------
module eof_error_block
  import can_pkg::*;
#(
  parameter int unsigned EOF_LEN = EOF_LEN_DEFAULT
) (
  input  logic SP,
  input  logic reset,
  input  logic RX,
  input  logic EOF_Flag,
  output logic EOF_Error
);

  eof_state_t state;
  logic       last_bit;     // current sample is EOF bit EOF_LEN
  logic       bit_checked;  // current sample contributes to the error
  logic       cnt_enable;

  // Count only while checking; the arming edge reloads instead.
  assign cnt_enable = (state == CHECK) && !EOF_Flag;

  eof_bit_counter #(
    .LAST (EOF_LEN - 1)
  ) u_bit_counter (
    .SP     (SP),
    .reset  (reset),
    .load   (EOF_Flag),
    .enable (cnt_enable),
    .tc     (last_bit)
  );

`ifdef EOF_LAST_BIT_OVERLOAD_EN
  // The final EOF bit is excluded from the check.
  always_comb begin
    bit_checked = 1'b0;
    if (last_bit) begin
      bit_checked = 1'b0;
    end else begin
      bit_checked = 1'b1;
    end
  end
`else
  // Every EOF bit is checked.
  always_comb begin
    bit_checked = 1'b1;
  end
`endif

  // Checker FSM and sticky error register; priority reset > arm > check.
  always_ff @(posedge SP) begin
    if (reset) begin
      state     <= IDLE;
      EOF_Error <= 1'b0;
    end else if (EOF_Flag) begin
      state     <= CHECK;
      EOF_Error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state     <= IDLE;
          EOF_Error <= EOF_Error;
        end
        CHECK: begin
          if (bit_checked && (RX == CAN_DOMINANT)) begin
            EOF_Error <= 1'b1;
          end else begin
            EOF_Error <= EOF_Error;
          end
          if (last_bit) begin
            state <= IDLE;
          end else begin
            state <= CHECK;
          end
        end
        default: begin
          state     <= IDLE;
          EOF_Error <= EOF_Error;
        end
      endcase
    end
  end

endmodule : eof_error_block

// File: tb/tb_eof_error_block.sv
// ---------------------------------------------------------------------------
// tb_eof_error_block
// Directed self-checking bench for eof_error_block with EOF_LEN = 7.
// Inputs change 1 time unit after each rising SP edge; EOF_Error is
// compared 1 time unit after the edge that consumed those inputs.
// ---------------------------------------------------------------------------
module tb_eof_error_block;
  import can_pkg::*;

  logic SP;
  logic reset;
  logic RX;
  logic EOF_Flag;
  logic EOF_Error;

  int checks;
  int errors;

`ifdef EOF_LAST_BIT_OVERLOAD_EN
  localparam logic LAST_BIT_ERR = 1'b0;
`else
  localparam logic LAST_BIT_ERR = 1'b1;
`endif

  eof_error_block #(
    .EOF_LEN (7)
  ) dut (
    .SP        (SP),
    .reset     (reset),
    .RX        (RX),
    .EOF_Flag  (EOF_Flag),
    .EOF_Error (EOF_Error)
  );

  initial begin
    SP = 1'b0;
    forever #5 SP = ~SP;
  end

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one bit, let one SP edge consume it, then compare EOF_Error.
  task automatic step(input logic rst, input logic flag, input logic rx,
                      input logic exp_err, input string tag);
    reset    = rst;
    EOF_Flag = flag;
    RX       = rx;
    @(posedge SP);
    #1;
    check_eq(tag, {3'd0, EOF_Error}, {3'd0, exp_err});
  endtask

  task automatic check_idle(input string tag);
    check_eq(tag, (dut.state == IDLE) ? 4'd1 : 4'd0, 4'd1);
  endtask

  initial begin
    logic [6:0] bits;
    logic [6:0] errs;
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    EOF_Flag = 1'b0;
    RX       = 1'b1;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, "reset");
    check_idle("reset_state");
    step(1'b0, 1'b0, 1'b0, 1'b0, "idle_ignores_rx");

    // All recessive, then re-arm with a dominant arming bit
    step(1'b0, 1'b1, 1'b1, 1'b0, "rec_arm");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b0, "rec_bit");
    step(1'b0, 1'b1, 1'b0, 1'b0, "rearm_rx_unchecked");

    // Dominant on bit 4 (re-armed directly above, so arm once more)
    step(1'b0, 1'b1, 1'b1, 1'b0, "b4_arm");
    bits = 7'b1110111; // bit1 is LSB
    errs = 7'b1111000;
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, bits[i], errs[i], "b4_bit");
    step(1'b0, 1'b0, 1'b1, 1'b1, "b4_idle_hold");
    check_idle("b4_idle");

    // Dominant on bit 1; arm clears the previous error
    step(1'b0, 1'b1, 1'b1, 1'b0, "b1_arm_clears");
    step(1'b0, 1'b0, 1'b0, 1'b1, "b1_first");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b1, "b1_sticky");

    // Clear on re-arm followed by a clean EOF; dominant in IDLE ignored
    step(1'b0, 1'b1, 1'b1, 1'b0, "clr_arm");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b0, "clr_clean");
    step(1'b0, 1'b0, 1'b0, 1'b0, "clr_idle_rx0");
    step(1'b0, 1'b0, 1'b0, 1'b0, "clr_idle_rx0b");

    // Dominant on bit 6 is always checked
    step(1'b0, 1'b1, 1'b1, 1'b0, "b6_arm");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, "b6_pre");
    step(1'b0, 1'b0, 1'b0, 1'b1, "b6_dom");
    step(1'b0, 1'b0, 1'b1, 1'b1, "b6_last");

    // Mid-EOF re-arm restarts at bit 1, then dominant only on bit 7,
    // then a dominant bit just past the window is ignored
    step(1'b0, 1'b1, 1'b1, 1'b0, "mid_arm");
    step(1'b0, 1'b0, 1'b0, 1'b1, "mid_err");
    step(1'b0, 1'b0, 1'b1, 1'b1, "mid_hold");
    step(1'b0, 1'b1, 1'b1, 1'b0, "mid_rearm_clears");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0, "b7_pre");
    step(1'b0, 1'b0, 1'b0, LAST_BIT_ERR, "b7_dom");
    step(1'b0, 1'b0, 1'b0, LAST_BIT_ERR, "after_window");
    check_idle("after_window_state");

    // Reset mid-EOF aborts the check
    step(1'b0, 1'b1, 1'b1, 1'b0, "rst_arm");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, "rst_pre");
    step(1'b1, 1'b0, 1'b1, 1'b0, "rst_mid");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "rst_after");
    check_idle("rst_state");

    // Reset clears a set error
    step(1'b0, 1'b1, 1'b1, 1'b0, "rst2_arm");
    step(1'b0, 1'b0, 1'b0, 1'b1, "rst2_err");
    step(1'b1, 1'b0, 1'b0, 1'b0, "rst2_clear");
    check_idle("rst2_state");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_eof_error_block
